// File: rtl/stop_watch_lap.sv
// Stopwatch with min:sec:centisecond counters, a lap-capture FIFO and an
// optional countdown mode enabled by defining STOP_WATCH_DOWN_EN.
module stop_watch_lap #(
  parameter int unsigned CS_MOD    = 100,
  parameter int unsigned SEC_MOD   = 60,
  parameter int unsigned MIN_MOD   = 100,
  parameter int unsigned LAP_DEPTH = 4,
  localparam int unsigned CW = $clog2(CS_MOD),
  localparam int unsigned SW = $clog2(SEC_MOD),
  localparam int unsigned MW = $clog2(MIN_MOD),
  localparam int unsigned LW = $clog2(LAP_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pls_in,
  input  logic          start_stop,
  input  logic          clr,
  input  logic          lap,
  input  logic          lap_rd,
  input  logic          mode_dn,
  input  logic [MW-1:0] pre_m,
  input  logic [SW-1:0] pre_s,
  input  logic [CW-1:0] pre_cs,
  output logic [CW-1:0] cs_cnt,
  output logic [SW-1:0] s_cnt,
  output logic [MW-1:0] m_cnt,
  output logic [CW-1:0] lap_cs,
  output logic [SW-1:0] lap_s,
  output logic [MW-1:0] lap_m,
  output logic          lap_valid,
  output logic [LW-1:0] lap_num,
  output logic          running,
  output logic          wrap,
  output logic          lap_ovf,
  output logic          done
);

  localparam int unsigned PW = LW - 1;
  localparam int unsigned EW = MW + SW + CW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CW-1:0] CS_MAX  = CW'(CS_MOD - 1);
  localparam logic [SW-1:0] SEC_MAX = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] MIN_MAX = MW'(MIN_MOD - 1);

  logic          p0_q, p1_q, tick;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cs_q, cs_d;
  logic [SW-1:0] s_q, s_d;
  logic [MW-1:0] m_q, m_d;
  logic          wrap_q, wrap_d;
  logic          down_q, down_d;
  logic          cnt_zero;

  assign tick     = p1_q & ~p0_q;
  assign cnt_zero = (cs_q == '0) && (s_q == '0) && (m_q == '0);

`ifdef STOP_WATCH_DOWN_EN
  logic [CW-1:0] pre_cs_sat;
  logic [SW-1:0] pre_s_sat;
  logic [MW-1:0] pre_m_sat;
  assign pre_cs_sat = ({1'b0, pre_cs} >= (CW + 1)'(CS_MOD))  ? CS_MAX  : pre_cs;
  assign pre_s_sat  = ({1'b0, pre_s}  >= (SW + 1)'(SEC_MOD)) ? SEC_MAX : pre_s;
  assign pre_m_sat  = ({1'b0, pre_m}  >= (MW + 1)'(MIN_MOD)) ? MIN_MAX : pre_m;
  assign done       = (state_q == ST_DONE);
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode_dn, pre_m, pre_s, pre_cs};
  assign done       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    s_d     = s_q;
    m_d     = m_q;
    wrap_d  = 1'b0;
    down_d  = down_q;
    if (clr) begin
      state_d = ST_IDLE;
      cs_d    = '0;
      s_d     = '0;
      m_d     = '0;
      down_d  = 1'b0;
`ifdef STOP_WATCH_DOWN_EN
      if (state_q == ST_IDLE && mode_dn) begin
        cs_d   = pre_cs_sat;
        s_d    = pre_s_sat;
        m_d    = pre_m_sat;
        down_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        ST_IDLE:  if (start_stop) state_d = (down_q && cnt_zero) ? ST_DONE : ST_RUN;
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        ST_RUN: begin
          if (start_stop) state_d = ST_PAUSE;
          if (tick) begin
            if (down_q) begin
              if (cs_q != '0) begin
                cs_d = cs_q - 1'b1;
              end else begin
                cs_d = CS_MAX;
                if (s_q != '0) begin
                  s_d = s_q - 1'b1;
                end else begin
                  s_d = SEC_MAX;
                  m_d = m_q - 1'b1;
                end
              end
              // Reaching zero (or already there) ends the countdown and holds at 0.
              if (cnt_zero || {m_d, s_d, cs_d} == '0) begin
                cs_d    = '0;
                s_d     = '0;
                m_d     = '0;
                state_d = ST_DONE;
              end
            end else if (cs_q != CS_MAX) begin
              cs_d = cs_q + 1'b1;
            end else begin
              cs_d = '0;
              if (s_q != SEC_MAX) begin
                s_d = s_q + 1'b1;
              end else begin
                s_d = '0;
                if (m_q != MIN_MAX) begin
                  m_d = m_q + 1'b1;
                end else begin
                  m_d    = '0;
                  wrap_d = 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_q    <= 1'b0;
      p1_q    <= 1'b0;
      state_q <= ST_IDLE;
      cs_q    <= '0;
      s_q     <= '0;
      m_q     <= '0;
      wrap_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      p0_q    <= pls_in;
      p1_q    <= p0_q;
      state_q <= state_d;
      cs_q    <= cs_d;
      s_q     <= s_d;
      m_q     <= m_d;
      wrap_q  <= wrap_d;
      down_q  <= down_d;
    end
  end

  // Lap FIFO: captures the pre-edge time, head register trails the pointers by one cycle.
  logic [EW-1:0] mem [LAP_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] cnt_q;
  logic          ovf_q;
  logic [EW-1:0] head_q;
  logic          full, push_req, push, pop;

  assign full     = (cnt_q == LW'(LAP_DEPTH));
  assign push_req = lap && !clr && (state_q == ST_RUN || state_q == ST_PAUSE);
  assign pop      = lap_rd && !clr && (cnt_q != '0);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {m_q, s_q, cs_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else if (clr) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
      head_q <= (cnt_q == '0) ? '0 : mem[rd_q];
    end
  end

  assign cs_cnt    = cs_q;
  assign s_cnt     = s_q;
  assign m_cnt     = m_q;
  assign lap_cs    = head_q[CW-1:0];
  assign lap_s     = head_q[CW+SW-1:CW];
  assign lap_m     = head_q[EW-1:CW+SW];
  assign lap_valid = (cnt_q != '0);
  assign lap_num   = cnt_q;
  assign running   = (state_q == ST_RUN);
  assign wrap      = wrap_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Scoreboard bench for stop_watch_lap: default-size instance plus a tiny-modulus
// instance for full-scale wrap; countdown cases follow STOP_WATCH_DOWN_EN.
module tb_stop_watch_lap;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pls_in = 1'b0, start_stop = 1'b0, clr = 1'b0, lap = 1'b0, lap_rd = 1'b0;
  logic mode_dn = 1'b0;
  logic [6:0] pre_m = '0;
  logic [5:0] pre_s = '0;
  logic [6:0] pre_cs = '0;
  logic [6:0] cs_cnt, lap_cs, m_cnt, lap_m;
  logic [5:0] s_cnt, lap_s;
  logic       lap_valid, running, wrap, lap_ovf, done;
  logic [2:0] lap_num;

  logic [0:0] sm_pre_m = '0, sm_m, sm_lap_m;
  logic [1:0] sm_pre_s = '0, sm_s, sm_lap_s;
  logic [1:0] sm_pre_cs = '0, sm_cs, sm_lap_cs;
  logic [1:0] sm_lap_num;
  logic       sm_lap_valid, sm_running, sm_wrap, sm_lap_ovf, sm_done;

  int n_checks = 0;
  int n_pass = 0;
  int wrap_hi = 0;

  always #4 clk = ~clk;

  stop_watch_lap u_dut (
    .clk(clk), .rst(rst), .pls_in(pls_in), .start_stop(start_stop), .clr(clr),
    .lap(lap), .lap_rd(lap_rd), .mode_dn(mode_dn),
    .pre_m(pre_m), .pre_s(pre_s), .pre_cs(pre_cs),
    .cs_cnt(cs_cnt), .s_cnt(s_cnt), .m_cnt(m_cnt),
    .lap_cs(lap_cs), .lap_s(lap_s), .lap_m(lap_m),
    .lap_valid(lap_valid), .lap_num(lap_num), .running(running), .wrap(wrap),
    .lap_ovf(lap_ovf), .done(done)
  );

  stop_watch_lap #(.CS_MOD(4), .SEC_MOD(3), .MIN_MOD(2), .LAP_DEPTH(2)) u_small (
    .clk(clk), .rst(rst), .pls_in(pls_in), .start_stop(start_stop), .clr(clr),
    .lap(lap), .lap_rd(lap_rd), .mode_dn(mode_dn),
    .pre_m(sm_pre_m), .pre_s(sm_pre_s), .pre_cs(sm_pre_cs),
    .cs_cnt(sm_cs), .s_cnt(sm_s), .m_cnt(sm_m),
    .lap_cs(sm_lap_cs), .lap_s(sm_lap_s), .lap_m(sm_lap_m),
    .lap_valid(sm_lap_valid), .lap_num(sm_lap_num), .running(sm_running),
    .wrap(sm_wrap), .lap_ovf(sm_lap_ovf), .done(sm_done)
  );

  localparam int F_CS = 0, F_S = 1, F_M = 2, F_RUN = 3, F_WRAP = 4, F_LV = 5, F_LN = 6;
  localparam int F_OVF = 7, F_DONE = 8, F_LCS = 9, F_LS = 10, F_LM = 11;
  localparam int F_SCS = 12, F_SS = 13, F_SM = 14, F_SRUN = 15, F_SWRAPCNT = 16;

  typedef struct {
    string       tag;
    int          field;
    int unsigned exp;
  } exp_t;

  exp_t sb_q[$];

  function automatic int unsigned observe(int f);
    case (f)
      F_CS:       return int'(cs_cnt);
      F_S:        return int'(s_cnt);
      F_M:        return int'(m_cnt);
      F_RUN:      return int'(running);
      F_WRAP:     return int'(wrap);
      F_LV:       return int'(lap_valid);
      F_LN:       return int'(lap_num);
      F_OVF:      return int'(lap_ovf);
      F_DONE:     return int'(done);
      F_LCS:      return int'(lap_cs);
      F_LS:       return int'(lap_s);
      F_LM:       return int'(lap_m);
      F_SCS:      return int'(sm_cs);
      F_SS:       return int'(sm_s);
      F_SM:       return int'(sm_m);
      F_SRUN:     return int'(sm_running);
      F_SWRAPCNT: return wrap_hi;
      default:    return 32'hdead_beef;
    endcase
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input int f, input int unsigned e);
    exp_t x;
    x.tag   = tag;
    x.field = f;
    x.exp   = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_eq(x.tag, observe(x.field), x.exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic ss, input logic c, input logic l, input logic r);
    @(negedge clk);
    start_stop = ss; clr = c; lap = l; lap_rd = r;
    @(negedge clk);
    start_stop = 1'b0; clr = 1'b0; lap = 1'b0; lap_rd = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pls_in = 1'b1;
      cycles(3);
      pls_in = 1'b0;
      cycles(3);
    end
  endtask

  // Strobes land on the same edge that consumes the tick.
  task automatic tick_with(input logic ss, input logic c, input logic l);
    pls_in = 1'b1;
    cycles(3);
    pls_in = 1'b0;
    @(negedge clk);
    start_stop = ss; clr = c; lap = l;
    @(negedge clk);
    start_stop = 1'b0; clr = 1'b0; lap = 1'b0;
    cycles(2);
  endtask

  task automatic load_preset(input int m, input int s, input int cs);
    mode_dn = 1'b0;
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    pre_m = 7'(m); pre_s = 6'(s); pre_cs = 7'(cs);
    mode_dn = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    mode_dn = 1'b0;
  endtask

  initial begin
    #(8 * 60000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    cycles(3);
    expect_val("rst_cs", F_CS, 0);     expect_val("rst_s", F_S, 0);
    expect_val("rst_m", F_M, 0);       expect_val("rst_run", F_RUN, 0);
    expect_val("rst_wrap", F_WRAP, 0); expect_val("rst_lv", F_LV, 0);
    expect_val("rst_ln", F_LN, 0);     expect_val("rst_ovf", F_OVF, 0);
    expect_val("rst_done", F_DONE, 0); expect_val("rst_lcs", F_LCS, 0);
    drain();
    rst = 1'b1;
    cycles(2);

    // Up run
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(150);
    expect_val("up_cs", F_CS, 50); expect_val("up_s", F_S, 1);
    expect_val("up_m", F_M, 0);    expect_val("up_run", F_RUN, 1);
    drain();

    // Pause / resume
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(40);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("pause_run", F_RUN, 0);
    ticks(20);
    expect_val("pause_cs", F_CS, 40); expect_val("pause_s", F_S, 0);
    drain();
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    expect_val("resume_cs", F_CS, 45); expect_val("resume_run", F_RUN, 1);
    drain();

    // Laps at 45,48,51,54,57; the fifth is dropped
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3);
    end
    cycles(1);
    expect_val("lap_num4", F_LN, 4); expect_val("lap_valid", F_LV, 1);
    expect_val("lap_ovf", F_OVF, 1); expect_val("lap_head0", F_LCS, 45);
    expect_val("lap_head_s", F_LS, 0);
    drain();
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    cycles(1);
    expect_val("full_pp_num", F_LN, 4); expect_val("full_pp_head", F_LCS, 48);
    drain();
    begin
      int heads[3] = '{51, 54, 60};
      for (int i = 0; i < 3; i++) begin
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        cycles(1);
        expect_val("pop_head", F_LCS, heads[i]);
        drain();
      end
    end
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    cycles(1);
    expect_val("empty_lv", F_LV, 0); expect_val("empty_ln", F_LN, 0);
    expect_val("empty_lcs", F_LCS, 0); expect_val("empty_ls", F_LS, 0);
    expect_val("empty_lm", F_LM, 0);
    drain();
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    cycles(1);
    expect_val("empty_pp_num", F_LN, 1); expect_val("empty_pp_head", F_LCS, 60);
    expect_val("ovf_sticky", F_OVF, 1);
    drain();

    // Tick, start_stop and lap on one edge in RUN
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    tick_with(1'b1, 1'b0, 1'b1);
    cycles(1);
    expect_val("tss_cs", F_CS, 61); expect_val("tss_run", F_RUN, 0);
    expect_val("tss_ln", F_LN, 1);  expect_val("tss_lap_pre", F_LCS, 60);
    drain();

    // Lap ignored in IDLE; clr clears ovf
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    expect_val("clr_ovf", F_OVF, 0); expect_val("clr_cs", F_CS, 0);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    cycles(1);
    expect_val("idle_lap_ln", F_LN, 0);
    drain();

    // clr priority
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    expect_val("prio_pre_ln", F_LN, 1);
    drain();
    tick_with(1'b1, 1'b1, 1'b1);
    expect_val("prio_cs", F_CS, 0); expect_val("prio_run", F_RUN, 0);
    expect_val("prio_ln", F_LN, 0); expect_val("prio_lv", F_LV, 0);
    drain();
    ticks(3);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    cycles(1);
    expect_val("prio_idle_cs", F_CS, 0); expect_val("prio_idle_lap", F_LN, 0);
    drain();

    // Full-scale wrap on the small instance (4 x 3 x 2)
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(23);
    expect_val("sm_max_m", F_SM, 1); expect_val("sm_max_s", F_SS, 2);
    expect_val("sm_max_cs", F_SCS, 3);
    drain();
    pls_in = 1'b1;
    cycles(3);
    pls_in = 1'b0;
    wrap_hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (sm_wrap) wrap_hi++;
    end
    expect_val("wrap_cycles", F_SWRAPCNT, 1);
    expect_val("wrap_cs", F_SCS, 0); expect_val("wrap_s", F_SS, 0);
    expect_val("wrap_m", F_SM, 0);   expect_val("wrap_run", F_SRUN, 1);
    expect_val("main_nowrap", F_WRAP, 0);
    drain();

    // Reset mid-run
    ticks(10);
    rst = 1'b0;
    #1;
    expect_val("midrst_cs", F_CS, 0); expect_val("midrst_run", F_RUN, 0);
    drain();
    cycles(2);
    rst = 1'b1;
    ticks(3);
    expect_val("postrst_cs", F_CS, 0); expect_val("postrst_run", F_RUN, 0);
    drain();
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2);
    expect_val("restart_cs", F_CS, 2); expect_val("restart_run", F_RUN, 1);
    drain();

`ifdef STOP_WATCH_DOWN_EN
    load_preset(0, 1, 5);
    expect_val("dn_load_cs", F_CS, 5); expect_val("dn_load_s", F_S, 1);
    drain();
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(104);
    expect_val("dn_cs1", F_CS, 1); expect_val("dn_done0", F_DONE, 0);
    drain();
    ticks(1);
    expect_val("dn_done", F_DONE, 1); expect_val("dn_cs", F_CS, 0);
    expect_val("dn_s", F_S, 0);       expect_val("dn_m", F_M, 0);
    expect_val("dn_run", F_RUN, 0);
    drain();
    ticks(5);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("dn_hold_cs", F_CS, 0); expect_val("dn_hold_done", F_DONE, 1);
    drain();
    load_preset(127, 63, 120);
    expect_val("sat_cs", F_CS, 99); expect_val("sat_s", F_S, 59);
    expect_val("sat_m", F_M, 99);
    drain();
    load_preset(0, 0, 0);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    expect_val("zero_pre_done", F_DONE, 1); expect_val("zero_pre_run", F_RUN, 0);
    drain();
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    expect_val("dn_clr_done", F_DONE, 0);
    drain();
`else
    load_preset(0, 1, 5);
    expect_val("nodn_cs", F_CS, 0); expect_val("nodn_s", F_S, 0);
    expect_val("nodn_done", F_DONE, 0);
    drain();
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2);
    expect_val("nodn_up_cs", F_CS, 2); expect_val("nodn_run", F_RUN, 1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stop_watch_lap.md
STOP_WATCH_LAP -- requirements
Module: stop_watch_lap

Interface
Parameters:
REQ-001 CS_MOD, default 100: sub-second digit modulus.
REQ-002 SEC_MOD, default 60: seconds modulus.
REQ-003 MIN_MOD, default 100: minutes modulus.
REQ-004 LAP_DEPTH, default 4: lap FIFO entries, power of two, 2..16.
REQ-005 Widths: CW = ceil(log2(CS_MOD)), SW = ceil(log2(SEC_MOD)), MW = ceil(log2(MIN_MOD)), LW = log2(LAP_DEPTH)+1.
Ports:
REQ-006 clk  in  1  system clock, 125 MHz.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 pls_in  in  1  100 Hz time base; each falling edge is one tick.
REQ-009 start_stop  in  1  single-cycle strobe that toggles run/pause.
REQ-010 clr  in  1  single-cycle strobe, high-active clear.
REQ-011 lap  in  1  single-cycle strobe that captures the current time into the FIFO.
REQ-012 lap_rd  in  1  single-cycle strobe that pops the FIFO head.
REQ-013 mode_dn  in  1  1 selects countdown; sampled only in IDLE.
REQ-014 pre_m/pre_s/pre_cs  in  MW/SW/CW  countdown preset.
REQ-015 cs_cnt/s_cnt/m_cnt  out  CW/SW/MW  live time.
REQ-016 lap_cs/lap_s/lap_m  out  CW/SW/MW  FIFO head; zero when the FIFO is empty.
REQ-017 lap_valid  out  1  FIFO not empty; lap_num  out  LW  FIFO occupancy.
REQ-018 running  out  1  state is RUN; wrap  out  1  one-cycle pulse on full-scale wrap.
REQ-019 lap_ovf  out  1  sticky flag for a lap dropped on full FIFO; done  out  1  countdown reached zero.

Function
REQ-020 Tick detection: pls_in passes through a 2-flop sampler (p0, p1); tick = p1 & ~p0 for exactly one clk cycle.
REQ-021 FSM states are IDLE, RUN, PAUSE and DONE; all transitions are evaluated on posedge clk.
REQ-022 IDLE + start_stop goes to RUN; RUN + start_stop goes to PAUSE; PAUSE + start_stop goes to RUN.
REQ-023 clr from any state goes to IDLE.
REQ-024 clr has priority over every other input in the same cycle.
REQ-025 A tick advances the count only if the current (pre-edge) state is RUN; the updated count is visible on the edge where the tick is high.
REQ-026 Up count increments cs_cnt; CS_MOD-1 carries into s_cnt, SEC_MOD-1 carries into m_cnt.
REQ-027 Up count at MIN_MOD-1 : SEC_MOD-1 : CS_MOD-1 rolls to 0:0:0, pulses wrap for 1 cycle, and remains in RUN.
REQ-028 start_stop and tick in the same cycle in RUN: the tick is counted and the state becomes PAUSE.
REQ-029 clr in up mode zeroes all counters, flushes the FIFO, and clears lap_ovf, wrap and done.
REQ-030 lap in RUN or PAUSE pushes the pre-edge {m, s, cs}, so a same-cycle tick is excluded.
REQ-031 lap in IDLE or DONE is ignored.
REQ-032 lap_rd pops the FIFO head when lap_valid=1 and is ignored when empty.
REQ-033 lap on a full FIFO with no pop drops the entry and sets lap_ovf.
REQ-034 Push and pop in the same cycle on a full FIFO are both performed and lap_num is unchanged.
REQ-035 Push and pop in the same cycle on an empty FIFO: the push is performed and the pop is ignored.
REQ-036 FIFO head outputs are registered and reflect the new head one cycle after the push or pop edge.
REQ-037 Preset values at or above their modulus are saturated to modulus-1 on load.

Reset
REQ-038 While rst=0: FSM=IDLE, p0=p1=0, all counters 0, FIFO empty, and every output 0.
REQ-039 Reset mid-RUN aborts immediately with no partial carry; operation restarts in IDLE after rst returns to 1.
REQ-040 Internal down-mode select resets to 0 (up mode).

Configuration
REQ-041 The feature macro is STOP_WATCH_DOWN_EN.
REQ-042 With STOP_WATCH_DOWN_EN defined, clr in IDLE with mode_dn=1 loads pre_* into the counters and latches down mode.
REQ-043 In down mode a tick decrements cs_cnt, with borrows into s_cnt and m_cnt.
REQ-044 In down mode, reaching 0:0:0 goes to DONE with done=1 and counters held at 0; only clr exits DONE.
REQ-045 In down mode, start_stop from IDLE with a zero preset goes directly to DONE.
REQ-046 Without STOP_WATCH_DOWN_EN, mode_dn and pre_* are ignored, done is constant 0, and DONE is unreachable.

Verification
REQ-047 Up run: start_stop, then 150 pls_in falling edges -> s_cnt=1, cs_cnt=50, running=1.
REQ-048 Pause: start_stop at count 0:0:40, then 20 ticks -> count stays 0:0:40; start_stop and 5 ticks -> 0:0:45.
REQ-049 Wrap: reach 99:59:99, then 1 tick -> 0:0:0, wrap high for exactly 1 clk, FSM stays RUN.
REQ-050 Laps (LAP_DEPTH=4): 5 lap strobes at distinct times -> lap_num=4, lap_ovf=1, first lap at head.
REQ-051 Laps, continued: 4 lap_rd strobes -> lap_valid=0 and head outputs 0.
REQ-052 Down mode (macro on): preset 0:1:5, clr, start_stop, then 105 ticks -> done=1, count 0:0:0; extra ticks leave it unchanged.
REQ-053 Priority: clr, start_stop, lap and tick asserted in one cycle in RUN -> IDLE, count 0, FIFO empty.
